cv32e40p_mult_fault_mgr: RTL and testbench
==========================================

CV32E40P_MULT_FAULT_MGR -- requirements
Module: cv32e40p_mult_fault_mgr

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2: number of consecutive re-executions allowed before an alarm is raised; legal range 1..7.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the total fault counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable_i  input  1  a multiply operation is active in EX.
REQ-006 SHALL have port ready_i  input  1  voted multiplier ready; the result is final this cycle.
REQ-007 SHALL have port ex_ready_i  input  1  EX stage is advancing.
REQ-008 SHALL have port result_fault_i, multicycle_fault_i, mulh_fault_i, ready_fault_i  input  1 each  voter mismatch flags from the TMR multiplier.
REQ-009 SHALL have port clear_i  input  1  synchronous software clear of status and counter.
REQ-010 SHALL have port irq_ack_i  input  1  alarm acknowledge.
REQ-011 SHALL have port retry_o  output  1  request to squash and re-issue the current multiply.
REQ-012 SHALL have port fault_irq_o  output  1  persistent-fault alarm, level signal.
REQ-013 SHALL have port fault_status_o  output  4  sticky syndrome: bit 0 result, bit 1 multicycle, bit 2 mulh, bit 3 ready.
REQ-014 SHALL have port fault_count_o  output  CNT_WIDTH  total sampled faults, saturating.
REQ-015 SHALL have port retry_cnt_o  output  3  consecutive retries in the current episode.

Function
REQ-016 SHALL define a sample event as enable_i & ready_i & ex_ready_i.
REQ-017 SHALL define syndrome as {ready_fault_i, mulh_fault_i, multicycle_fault_i, result_fault_i}, and a faulty sample as a sample event with a nonzero syndrome.
REQ-018 SHALL ignore all fault flags outside sample events; flags SHALL have no effect on state, status or counters.
REQ-019 SHALL implement the FSM states IDLE, RETRY and ALARM, with all outputs registered.
REQ-020 SHALL, in IDLE on a faulty sample with retry_cnt < MAX_RETRY: go to RETRY and increment retry_cnt.
REQ-021 SHALL, in IDLE on a faulty sample with retry_cnt == MAX_RETRY: go to ALARM.
REQ-022 SHALL, in IDLE on a clean sample: reset retry_cnt to 0 and stay in IDLE.
REQ-023 SHALL assert retry_o high for exactly one cycle in RETRY, then return unconditionally to IDLE; samples in RETRY SHALL only update status and counter.
REQ-024 SHALL hold fault_irq_o = 1 while in ALARM; no retries are issued in ALARM.
REQ-025 SHALL, in ALARM on irq_ack_i: go to IDLE and clear retry_cnt to 0; samples in ALARM SHALL still update status and counter.
REQ-026 SHALL set fault_status_o to fault_status_o | syndrome on every faulty sample, in any state.
REQ-027 SHALL increment fault_count_o by 1 per faulty sample, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-028 SHALL, on clear_i: load status and counter as if they were 0, then apply the same-cycle sample (status = syndrome, count = 0 or 1).
REQ-029 SHALL NOT let clear_i affect FSM state or retry_cnt.
REQ-030 SHALL give irq_ack_i no effect outside ALARM.
REQ-031 SHALL, when irq_ack_i and a faulty sample coincide in ALARM: go to IDLE with retry_cnt 0; that sample only updates status and counter.
REQ-032 SHALL produce retry_o and fault_irq_o in the cycle after the triggering sample (one-cycle latency).

Reset
REQ-033 SHALL, on rst_n low at any time including mid-RETRY or in ALARM: immediately force state IDLE, retry_o 0, fault_irq_o 0, fault_status_o 0, fault_count_o 0 and retry_cnt_o 0.
REQ-034 SHALL ignore inputs while rst_n is low and resume on the first rising clk edge after release.

Verification
REQ-035 SHALL cover: single result_fault_i sample -> next cycle retry_o=1 for one cycle, status=0001, count=1, retry_cnt=1; following clean sample -> retry_cnt=0.
REQ-036 SHALL cover: three consecutive faulty samples with MAX_RETRY=2 -> retry pulses after the first two, fault_irq_o=1 after the third, count=3; irq_ack_i -> IDLE, fault_irq_o=0.
REQ-037 SHALL cover: fault flags high with enable_i=1, ready_i=0 -> no change to any output.
REQ-038 SHALL cover: CNT_WIDTH=4, 20 faulty samples -> fault_count_o holds at 15.
REQ-039 SHALL cover: clear_i coinciding with a mulh_fault_i sample, status previously 1001 -> status=0100, count=1.
REQ-040 SHALL cover: rst_n asserted during RETRY and during ALARM -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/cv32e40p_mult_fault_mgr.sv
// Fault manager for the TMR multiplier: samples voter mismatch flags when a
// multiply result is final, requests bounded re-execution, raises a
// persistent-fault alarm, and keeps a sticky syndrome and a saturating count.
module cv32e40p_mult_fault_mgr #(
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 ready_i,
  input  logic                 ex_ready_i,
  input  logic                 result_fault_i,
  input  logic                 multicycle_fault_i,
  input  logic                 mulh_fault_i,
  input  logic                 ready_fault_i,
  input  logic                 clear_i,
  input  logic                 irq_ack_i,
  output logic                 retry_o,
  output logic                 fault_irq_o,
  output logic [3:0]           fault_status_o,
  output logic [CNT_WIDTH-1:0] fault_count_o,
  output logic [2:0]           retry_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RETRY = 2'd1,
    ALARM = 2'd2
  } state_e;

  localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

  state_e               state_q, state_d;
  logic [2:0]           retry_cnt_q, retry_cnt_d;
  logic                 retry_q, retry_d;
  logic                 irq_q, irq_d;
  logic [3:0]           status_q, status_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic       sample;
  logic [3:0] syndrome;
  logic       faulty;

  assign sample   = enable_i & ready_i & ex_ready_i;
  assign syndrome = {ready_fault_i, mulh_fault_i, multicycle_fault_i, result_fault_i};
  assign faulty   = sample & (|syndrome);

  // Next-state logic for the retry/alarm FSM and its registered outputs.
  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (faulty) begin
          if (retry_cnt_q < MaxRetry) begin
            state_d     = RETRY;
            retry_cnt_d = retry_cnt_q + 3'd1;
          end else begin
            state_d = ALARM;
          end
        end else if (sample) begin
          retry_cnt_d = '0;
        end
      end
      RETRY: begin
        state_d = IDLE;
      end
      ALARM: begin
        if (irq_ack_i) begin
          state_d     = IDLE;
          retry_cnt_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        retry_cnt_d = '0;
      end
    endcase
    retry_d = (state_d == RETRY);
    irq_d   = (state_d == ALARM);
  end

  // Sticky syndrome and saturating fault counter; clear acts as a zero base
  // so a same-cycle faulty sample is still recorded.
  always_comb begin
    status_d = clear_i ? 4'b0000 : status_q;
    count_d  = clear_i ? '0 : count_q;
    if (faulty) begin
      status_d = status_d | syndrome;
      if (count_d != '1) begin
        count_d = count_d + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      retry_cnt_q <= '0;
      retry_q     <= 1'b0;
      irq_q       <= 1'b0;
      status_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      retry_q     <= retry_d;
      irq_q       <= irq_d;
      status_q    <= status_d;
      count_q     <= count_d;
    end
  end

  assign retry_o        = retry_q;
  assign fault_irq_o    = irq_q;
  assign fault_status_o = status_q;
  assign fault_count_o  = count_q;
  assign retry_cnt_o    = retry_cnt_q;

endmodule

// File: tb/tb_cv32e40p_mult_fault_mgr.sv
// Self-checking bench for cv32e40p_mult_fault_mgr: directed vector table plus
// hand-written reset, alarm and saturation sequences.
module tb_cv32e40p_mult_fault_mgr;

  logic       clk;
  logic       rst_n;
  logic       enable_i, ready_i, ex_ready_i;
  logic       result_fault_i, multicycle_fault_i, mulh_fault_i, ready_fault_i;
  logic       clear_i, irq_ack_i;

  logic       retry_o, fault_irq_o;
  logic [3:0] fault_status_o;
  logic [7:0] fault_count_o;
  logic [2:0] retry_cnt_o;

  logic       retry1_o, fault_irq1_o;
  logic [3:0] fault_status1_o;
  logic [3:0] fault_count1_o;
  logic [2:0] retry_cnt1_o;

  int checks = 0;
  int errors = 0;

  cv32e40p_mult_fault_mgr #(.MAX_RETRY(2), .CNT_WIDTH(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable_i          (enable_i),
    .ready_i           (ready_i),
    .ex_ready_i        (ex_ready_i),
    .result_fault_i    (result_fault_i),
    .multicycle_fault_i(multicycle_fault_i),
    .mulh_fault_i      (mulh_fault_i),
    .ready_fault_i     (ready_fault_i),
    .clear_i           (clear_i),
    .irq_ack_i         (irq_ack_i),
    .retry_o           (retry_o),
    .fault_irq_o       (fault_irq_o),
    .fault_status_o    (fault_status_o),
    .fault_count_o     (fault_count_o),
    .retry_cnt_o       (retry_cnt_o)
  );

  cv32e40p_mult_fault_mgr #(.MAX_RETRY(2), .CNT_WIDTH(4)) dut4 (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable_i          (enable_i),
    .ready_i           (ready_i),
    .ex_ready_i        (ex_ready_i),
    .result_fault_i    (result_fault_i),
    .multicycle_fault_i(multicycle_fault_i),
    .mulh_fault_i      (mulh_fault_i),
    .ready_fault_i     (ready_fault_i),
    .clear_i           (clear_i),
    .irq_ack_i         (irq_ack_i),
    .retry_o           (retry1_o),
    .fault_irq_o       (fault_irq1_o),
    .fault_status_o    (fault_status1_o),
    .fault_count_o     (fault_count1_o),
    .retry_cnt_o       (retry_cnt1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en, rdy, exr;
    logic [3:0] synd;
    logic       clr, ack;
    logic       e_retry, e_irq;
    logic [3:0] e_st;
    logic [7:0] e_cnt;
    logic [2:0] e_rc;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic rdy, input logic exr,
                              input logic [3:0] synd, input logic clr, input logic ack,
                              input logic e_retry, input logic e_irq, input logic [3:0] e_st,
                              input logic [7:0] e_cnt, input logic [2:0] e_rc);
    vec_t v;
    v.en = en; v.rdy = rdy; v.exr = exr; v.synd = synd; v.clr = clr; v.ack = ack;
    v.e_retry = e_retry; v.e_irq = e_irq; v.e_st = e_st; v.e_cnt = e_cnt; v.e_rc = e_rc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    enable_i   = v.en;
    ready_i    = v.rdy;
    ex_ready_i = v.exr;
    {ready_fault_i, mulh_fault_i, multicycle_fault_i, result_fault_i} = v.synd;
    clear_i    = v.clr;
    irq_ack_i  = v.ack;
  endtask

  task automatic check_outs(input string name, input vec_t v);
    checks++;
    if (retry_o !== v.e_retry || fault_irq_o !== v.e_irq || fault_status_o !== v.e_st ||
        fault_count_o !== v.e_cnt || retry_cnt_o !== v.e_rc) begin
      errors++;
      $display("FAIL %s: got retry=%b irq=%b st=%b cnt=%0d rc=%0d, expected retry=%b irq=%b st=%b cnt=%0d rc=%0d",
               name, retry_o, fault_irq_o, fault_status_o, fault_count_o, retry_cnt_o,
               v.e_retry, v.e_irq, v.e_st, v.e_cnt, v.e_rc);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check_outs(name, v);
  endtask

  task automatic check_zero4(input string name);
    checks++;
    if (retry1_o !== 1'b0 || fault_irq1_o !== 1'b0 || fault_status1_o !== 4'd0 ||
        fault_count1_o !== 4'd0 || retry_cnt1_o !== 3'd0) begin
      errors++;
      $display("FAIL %s: narrow instance not zero: retry=%b irq=%b st=%b cnt=%0d rc=%0d, expected all 0",
               name, retry1_o, fault_irq1_o, fault_status1_o, fault_count1_o, retry_cnt1_o);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(0,0,0,4'b0000,0,0, 0,0,4'b0000,8'd0,3'd0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[17];
  vec_t idle_v;

  initial begin
    idle_v = mk(0,0,0,4'b0000,0,0, 0,0,4'b0000,8'd0,3'd0);
    //            en rdy exr synd     clr ack  retry irq status   count rc
    tbl[0]  = mk(1,1,1,4'b0001,0,0, 1,0,4'b0001,8'd1,3'd1);
    tbl[1]  = mk(0,0,0,4'b0000,0,0, 0,0,4'b0001,8'd1,3'd1);
    tbl[2]  = mk(1,1,1,4'b0000,0,0, 0,0,4'b0001,8'd1,3'd0);
    tbl[3]  = mk(1,0,1,4'b1111,0,0, 0,0,4'b0001,8'd1,3'd0);
    tbl[4]  = mk(1,1,0,4'b1111,0,0, 0,0,4'b0001,8'd1,3'd0);
    tbl[5]  = mk(1,1,1,4'b0010,0,0, 1,0,4'b0011,8'd2,3'd1);
    tbl[6]  = mk(0,0,0,4'b0000,0,0, 0,0,4'b0011,8'd2,3'd1);
    tbl[7]  = mk(1,1,1,4'b0100,0,0, 1,0,4'b0111,8'd3,3'd2);
    tbl[8]  = mk(0,0,0,4'b0000,0,0, 0,0,4'b0111,8'd3,3'd2);
    tbl[9]  = mk(1,1,1,4'b1000,0,0, 0,1,4'b1111,8'd4,3'd2);
    tbl[10] = mk(1,1,1,4'b0001,0,0, 0,1,4'b1111,8'd5,3'd2);
    tbl[11] = mk(1,1,1,4'b0001,0,1, 0,0,4'b1111,8'd6,3'd0);
    tbl[12] = mk(0,0,0,4'b0000,0,1, 0,0,4'b1111,8'd6,3'd0);
    tbl[13] = mk(0,0,0,4'b0000,1,0, 0,0,4'b0000,8'd0,3'd0);
    tbl[14] = mk(1,1,1,4'b1001,0,0, 1,0,4'b1001,8'd1,3'd1);
    tbl[15] = mk(1,1,1,4'b0100,1,0, 0,0,4'b0100,8'd1,3'd1);
    tbl[16] = mk(1,1,1,4'b0000,0,0, 0,0,4'b0100,8'd1,3'd0);

    do_reset();
    check_outs("reset_state", idle_v);
    check_zero4("reset_state_narrow");

    for (int i = 0; i < 17; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Three faulty samples separated by their retry cycles, then acknowledge.
    do_reset();
    step("seq3_s1",   mk(1,1,1,4'b0001,0,0, 1,0,4'b0001,8'd1,3'd1));
    step("seq3_gap1", mk(0,0,0,4'b0000,0,0, 0,0,4'b0001,8'd1,3'd1));
    step("seq3_s2",   mk(1,1,1,4'b0001,0,0, 1,0,4'b0001,8'd2,3'd2));
    step("seq3_gap2", mk(0,0,0,4'b0000,0,0, 0,0,4'b0001,8'd2,3'd2));
    step("seq3_s3",   mk(1,1,1,4'b0001,0,0, 0,1,4'b0001,8'd3,3'd2));
    step("seq3_hold", mk(0,0,0,4'b0000,0,0, 0,1,4'b0001,8'd3,3'd2));
    step("seq3_ack",  mk(0,0,0,4'b0000,0,1, 0,0,4'b0001,8'd3,3'd0));

    // Asynchronous reset while in RETRY.
    do_reset();
    step("rst_retry_pre", mk(1,1,1,4'b0010,0,0, 1,0,4'b0010,8'd1,3'd1));
    drive(idle_v);
    #1 rst_n = 1'b0;
    #1;
    check_outs("rst_in_retry", idle_v);
    check_zero4("rst_in_retry_narrow");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("rst_retry_post", idle_v);

    // Asynchronous reset while in ALARM.
    step("rst_alarm_s1", mk(1,1,1,4'b1000,0,0, 1,0,4'b1000,8'd1,3'd1));
    step("rst_alarm_g1", mk(0,0,0,4'b0000,0,0, 0,0,4'b1000,8'd1,3'd1));
    step("rst_alarm_s2", mk(1,1,1,4'b1000,0,0, 1,0,4'b1000,8'd2,3'd2));
    step("rst_alarm_g2", mk(0,0,0,4'b0000,0,0, 0,0,4'b1000,8'd2,3'd2));
    step("rst_alarm_s3", mk(1,1,1,4'b1000,0,0, 0,1,4'b1000,8'd3,3'd2));
    drive(idle_v);
    #1 rst_n = 1'b0;
    #1;
    check_outs("rst_in_alarm", idle_v);
    check_zero4("rst_in_alarm_narrow");
    // Inputs are ignored while reset is held.
    drive(mk(1,1,1,4'b1111,0,0, 0,0,4'b0000,8'd0,3'd0));
    @(posedge clk);
    #1;
    check_outs("rst_held_ignores_inputs", idle_v);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle_v);
    @(posedge clk);
    #1;

    // Saturation: 20 faulty samples, narrow counter sticks at 15.
    for (int k = 1; k <= 20; k++) begin
      drive(mk(1,1,1,4'b0001,0,1, 0,0,4'b0000,8'd0,3'd0));
      @(posedge clk);
      #1;
      checks++;
      if (fault_count1_o !== 4'((k > 15) ? 15 : k)) begin
        errors++;
        $display("FAIL sat_narrow_%0d: got %0d, expected %0d", k, fault_count1_o, (k > 15) ? 15 : k);
      end
      checks++;
      if (fault_count_o !== 8'(k)) begin
        errors++;
        $display("FAIL sat_wide_%0d: got %0d, expected %0d", k, fault_count_o, k);
      end
    end
    drive(idle_v);
    @(posedge clk);
    #1;
    checks++;
    if (fault_count1_o !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: got %0d, expected 15", fault_count1_o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
